// File: rtl/fmdll_pkg.sv
// Shared defaults and comparison classes for the FMDLL clock-ratio meter.
package fmdll_pkg;

    localparam int N_W_DEF      = 8;
    localparam int M_W_DEF      = 4;
    localparam int EV_W_DEF     = 2;
    localparam int TOL_DEF      = 1;
    localparam int LOCK_CNT_DEF = 4;

    typedef enum logic [1:0] {
        CMP_SLOW,
        CMP_BAND,
        CMP_FAST
    } cmp_e;

endpackage

// File: rtl/fmdll_ratio_meter_if.sv
// Control/result bundle between the FMDLL loop control and the ratio meter.
interface fmdll_ratio_meter_if
    import fmdll_pkg::*;
#(
    parameter int N_W  = N_W_DEF,
    parameter int M_W  = M_W_DEF,
    parameter int EV_W = EV_W_DEF
);

    logic [M_W-1:0]  M;
    logic [N_W-1:0]  N;
    logic            Sel;
    logic [EV_W-1:0] ev_cnt;
    logic [M_W-1:0]  M_counter;
    logic [N_W-1:0]  N_counter;
    logic            cmp_valid;
    logic [N_W-1:0]  result;
    logic            fast;
    logic            slow;
    logic            lock;

    modport master (
        output M, N, Sel, ev_cnt,
        input  M_counter, N_counter, cmp_valid, result, fast, slow, lock
    );

    modport slave (
        input  M, N, Sel, ev_cnt,
        output M_counter, N_counter, cmp_valid, result, fast, slow, lock
    );

endinterface

// File: rtl/fmdll_lock_filter.sv
// Hysteretic lock: counts consecutive in-band windows, drops on the first out-of-band one.
module fmdll_lock_filter #(
    parameter int LOCK_CNT = fmdll_pkg::LOCK_CNT_DEF
) (
    input  logic clk_ext,
    input  logic rst,
    input  logic valid,
    input  logic in_band,
    output logic lock
);

    localparam int            CW  = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] LIM = CW'(LOCK_CNT);

    logic [CW-1:0] cnt_p1;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_p1;
        if (valid) begin
            if (!in_band) begin
                cnt_nxt = '0;
            end else if (cnt_p1 != LIM) begin
                cnt_nxt = cnt_p1 + CW'(1);
            end
        end
    end

    // lock updates on the same edge that raises cmp_valid
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            cnt_p1 <= '0;
            lock   <= 1'b0;
        end else begin
            cnt_p1 <= cnt_nxt;
            if (valid) begin
                lock <= (cnt_nxt == LIM);
            end
        end
    end

endmodule

// File: rtl/fmdll_ratio_meter.sv
// Counts clk_out edge events over an M-cycle window of clk_ext and classifies the
// total against target N (fast/slow/in-band) with a hysteretic lock flag.
module fmdll_ratio_meter
    import fmdll_pkg::*;
#(
    parameter int N_W      = N_W_DEF,
    parameter int M_W      = M_W_DEF,
    parameter int EV_W     = EV_W_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input logic                 clk_ext,
    input logic                 rst,
    fmdll_ratio_meter_if.slave  bus
);

    localparam logic signed [N_W:0] TOL_S = (N_W+1)'(TOL);

    function automatic logic [N_W-1:0] sat_add(input logic [N_W-1:0] a, input logic [EV_W-1:0] b);
        logic [N_W:0] s;
        s = {1'b0, a} + {{(N_W+1-EV_W){1'b0}}, b};
        return s[N_W] ? '1 : s[N_W-1:0];
    endfunction

    function automatic cmp_e classify(input logic signed [N_W:0] d);
        if (d > TOL_S) begin
            return CMP_FAST;
        end else if (d < -TOL_S) begin
            return CMP_SLOW;
        end
        return CMP_BAND;
    endfunction

    logic [M_W-1:0]      m_sh;
    logic [N_W-1:0]      n_sh;
    logic [M_W-1:0]      m_cnt_p0;
    logic [N_W-1:0]      n_cnt_p0;
    logic                sel_seen_p0;
    logic [EV_W-1:0]     ev_eff_p0;
    logic [N_W-1:0]      sum_p0;
    logic                sel_any_p0;
    logic                win_end_p0;
    logic                cmp_ok_p0;
    logic                in_band_p0;
    logic signed [N_W:0] diff_p0;
    cmp_e                cls_p0;

    logic                vld_p1;
    logic [N_W-1:0]      tot_p1;
    logic                fast_p1;
    logic                slow_p1;
    logic                lock_p1;

    always_comb begin
        ev_eff_p0  = bus.Sel ? '0 : bus.ev_cnt;
        sum_p0     = sat_add(n_cnt_p0, ev_eff_p0);
        sel_any_p0 = sel_seen_p0 | bus.Sel;
        win_end_p0 = (m_sh != '0) && (m_cnt_p0 == m_sh);
        cmp_ok_p0  = win_end_p0 && !sel_any_p0;
        diff_p0    = $signed({1'b0, sum_p0}) - $signed({1'b0, n_sh});
        cls_p0     = classify(diff_p0);
        in_band_p0 = (cls_p0 == CMP_BAND);
    end

    // p0: window accumulation; an idle meter (m_sh==0) re-samples M/N every cycle
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            m_sh        <= '0;
            n_sh        <= '0;
            m_cnt_p0    <= '0;
            n_cnt_p0    <= '0;
            sel_seen_p0 <= 1'b0;
        end else if ((m_sh == '0) || win_end_p0) begin
            m_sh        <= bus.M;
            n_sh        <= bus.N;
            m_cnt_p0    <= (bus.M != '0) ? M_W'(1) : '0;
            n_cnt_p0    <= '0;
            sel_seen_p0 <= 1'b0;
        end else begin
            m_cnt_p0    <= m_cnt_p0 + M_W'(1);
            n_cnt_p0    <= sum_p0;
            sel_seen_p0 <= sel_any_p0;
        end
    end

    // p1: captured window result, held until the next unfrozen window ends
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            tot_p1  <= '0;
            fast_p1 <= 1'b0;
            slow_p1 <= 1'b0;
        end else begin
            vld_p1 <= cmp_ok_p0;
            if (cmp_ok_p0) begin
                tot_p1  <= sum_p0;
                fast_p1 <= (cls_p0 == CMP_FAST);
                slow_p1 <= (cls_p0 == CMP_SLOW);
            end
        end
    end

    fmdll_lock_filter #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk_ext (clk_ext),
        .rst     (rst),
        .valid   (cmp_ok_p0),
        .in_band (in_band_p0),
        .lock    (lock_p1)
    );

    assign bus.M_counter = m_cnt_p0;
    assign bus.N_counter = n_cnt_p0;
    assign bus.cmp_valid = vld_p1;
    assign bus.result    = tot_p1;
    assign bus.fast      = fast_p1;
    assign bus.slow      = slow_p1;
    assign bus.lock      = lock_p1;

endmodule

// File: tb/tb_fmdll_ratio_meter.sv
// Bench for fmdll_ratio_meter: two instances (N_W=8 and N_W=4) driven in lockstep,
// each compared every cycle against a window-level reference model.
module tb_fmdll_ratio_meter;

    localparam int TOL  = 1;
    localparam int LOCK = 4;

    logic clk_ext = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_ext = ~clk_ext;

    fmdll_ratio_meter_if #(.N_W(8), .M_W(4), .EV_W(2)) bus_a ();
    fmdll_ratio_meter_if #(.N_W(4), .M_W(4), .EV_W(2)) bus_b ();

    fmdll_ratio_meter #(.N_W(8), .M_W(4), .EV_W(2), .TOL(TOL), .LOCK_CNT(LOCK)) dut_a (
        .clk_ext (clk_ext),
        .rst     (rst),
        .bus     (bus_a.slave)
    );

    fmdll_ratio_meter #(.N_W(4), .M_W(4), .EV_W(2), .TOL(TOL), .LOCK_CNT(LOCK)) dut_b (
        .clk_ext (clk_ext),
        .rst     (rst),
        .bus     (bus_b.slave)
    );

    typedef struct packed {
        int msh;
        int nsh;
        int pos;
        int acc;
        bit frz;
        bit vld;
        int res;
        bit fast;
        bit slow;
        int streak;
        bit lock;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    // Model state = expected DUT outputs after the edge; acc is an unbounded true count.
    function automatic mdl_t mstep(mdl_t s_in, int m, int n, bit sel, int ev, int maxv);
        mdl_t s;
        int   tot;
        int   d;
        bit   start;
        s     = s_in;
        s.vld = 1'b0;
        start = (s.msh == 0);
        if (!start) begin
            if (sel) s.frz = 1'b1;
            else     s.acc = s.acc + ev;
            if (s.pos < s.msh) begin
                s.pos = s.pos + 1;
            end else begin
                if (!s.frz) begin
                    tot    = (s.acc > maxv) ? maxv : s.acc;
                    d      = tot - s.nsh;
                    s.vld  = 1'b1;
                    s.res  = tot;
                    s.fast = (d > TOL);
                    s.slow = (d < -TOL);
                    if (!s.fast && !s.slow) begin
                        if (s.streak < LOCK) s.streak = s.streak + 1;
                        s.lock = (s.streak == LOCK);
                    end else begin
                        s.streak = 0;
                        s.lock   = 1'b0;
                    end
                end
                start = 1'b1;
            end
        end
        if (start) begin
            s.msh = m;
            s.nsh = n;
            s.pos = (m != 0) ? 1 : 0;
            s.acc = 0;
            s.frz = 1'b0;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string t, input mdl_t s, input int maxv,
                           input logic [31:0] mc, input logic [31:0] nc, input logic [31:0] vld,
                           input logic [31:0] res, input logic [31:0] fst, input logic [31:0] slw,
                           input logic [31:0] lck);
        chk({t, "_M_counter"}, mc, s.pos);
        chk({t, "_N_counter"}, nc, (s.acc > maxv) ? maxv : s.acc);
        chk({t, "_cmp_valid"}, vld, 32'(s.vld));
        chk({t, "_result"}, res, s.res);
        chk({t, "_fast"}, fst, 32'(s.fast));
        chk({t, "_slow"}, slw, 32'(s.slow));
        chk({t, "_lock"}, lck, 32'(s.lock));
    endtask

    task automatic step(input bit r, input int m, input int n, input bit sel, input int ev);
        rst          = r;
        bus_a.M      = 4'(m);
        bus_a.N      = 8'(n);
        bus_a.Sel    = sel;
        bus_a.ev_cnt = 2'(ev);
        bus_b.M      = 4'(m);
        bus_b.N      = 4'(n & 15);
        bus_b.Sel    = sel;
        bus_b.ev_cnt = 2'(ev);
        if (r) begin
            ma = '0;
            mb = '0;
        end else begin
            ma = mstep(ma, m, n, sel, ev, 255);
            mb = mstep(mb, m, n & 15, sel, ev, 15);
        end
        @(posedge clk_ext);
        #1;
        chk_dut("a", ma, 255, 32'(bus_a.M_counter), 32'(bus_a.N_counter), 32'(bus_a.cmp_valid),
                32'(bus_a.result), 32'(bus_a.fast), 32'(bus_a.slow), 32'(bus_a.lock));
        chk_dut("b", mb, 15, 32'(bus_b.M_counter), 32'(bus_b.N_counter), 32'(bus_b.cmp_valid),
                32'(bus_b.result), 32'(bus_b.fast), 32'(bus_b.slow), 32'(bus_b.lock));
    endtask

    initial begin
        int rm;
        int rn;
        int rev;
        bit rsel;
        ma = '0;
        mb = '0;

        // Reset
        step(1'b1, 4, 8, 1'b0, 2);
        step(1'b1, 4, 8, 1'b0, 2);
        chk("rst_lock", 32'(bus_a.lock), 0);
        chk("rst_M_counter", 32'(bus_a.M_counter), 0);

        // Steady M=4, N=8, ev=2: lock on the 4th pulse
        repeat (17) step(1'b0, 4, 8, 1'b0, 2);
        chk("lock4_cmp_valid", 32'(bus_a.cmp_valid), 1);
        chk("lock4_result", 32'(bus_a.result), 8);
        chk("lock4_lock", 32'(bus_a.lock), 1);

        // One fast window drops lock together with its cmp_valid
        repeat (4) step(1'b0, 4, 8, 1'b0, 3);
        chk("fast_result", 32'(bus_a.result), 12);
        chk("fast_flag", 32'(bus_a.fast), 1);
        chk("fast_lock", 32'(bus_a.lock), 0);

        // Totals 7 and 9 in band, 6 slow
        step(1'b0, 4, 8, 1'b0, 2); step(1'b0, 4, 8, 1'b0, 2);
        step(1'b0, 4, 8, 1'b0, 2); step(1'b0, 4, 8, 1'b0, 1);
        chk("tot7_result", 32'(bus_a.result), 7);
        chk("tot7_slow", 32'(bus_a.slow), 0);
        step(1'b0, 4, 8, 1'b0, 3); step(1'b0, 4, 8, 1'b0, 2);
        step(1'b0, 4, 8, 1'b0, 2); step(1'b0, 4, 8, 1'b0, 2);
        chk("tot9_fast", 32'(bus_a.fast), 0);
        step(1'b0, 4, 8, 1'b0, 2); step(1'b0, 4, 8, 1'b0, 2);
        step(1'b0, 4, 8, 1'b0, 1); step(1'b0, 4, 8, 1'b0, 1);
        chk("tot6_slow", 32'(bus_a.slow), 1);

        // Relock, then freeze cycle 2 of a window
        repeat (16) step(1'b0, 4, 8, 1'b0, 2);
        chk("relock", 32'(bus_a.lock), 1);
        step(1'b0, 4, 8, 1'b0, 2);
        step(1'b0, 4, 8, 1'b1, 2);
        step(1'b0, 4, 8, 1'b0, 2);
        step(1'b0, 4, 8, 1'b0, 2);
        chk("frozen_no_pulse", 32'(bus_a.cmp_valid), 0);
        chk("frozen_lock_held", 32'(bus_a.lock), 1);
        repeat (4) step(1'b0, 4, 8, 1'b0, 2);
        chk("after_freeze_pulse", 32'(bus_a.cmp_valid), 1);
        chk("after_freeze_result", 32'(bus_a.result), 8);

        // M 4->2 mid-window
        repeat (4) step(1'b0, 2, 8, 1'b0, 2);
        chk("m_change_old_len", 32'(bus_a.cmp_valid), 1);
        step(1'b0, 2, 8, 1'b0, 2);
        chk("m_change_mid", 32'(bus_a.M_counter), 2);
        step(1'b0, 2, 8, 1'b0, 2);
        chk("m_change_new_len", 32'(bus_a.cmp_valid), 1);
        chk("m_change_result", 32'(bus_a.result), 4);

        // M=1: a window every cycle
        repeat (6) step(1'b0, 1, 2, 1'b0, 2);
        chk("m1_pulse", 32'(bus_a.cmp_valid), 1);

        // Saturation on the N_W=4 instance, M=8, ev=3
        step(1'b1, 8, 12, 1'b0, 3);
        repeat (7) step(1'b0, 8, 12, 1'b0, 3);
        chk("sat_N_counter", 32'(bus_b.N_counter), 15);
        repeat (2) step(1'b0, 8, 12, 1'b0, 3);
        chk("sat_result_b", 32'(bus_b.result), 15);
        chk("sat_result_a", 32'(bus_a.result), 24);

        // Reset mid-window
        repeat (3) step(1'b0, 8, 12, 1'b0, 3);
        step(1'b1, 8, 12, 1'b0, 3);
        chk("midrst_cmp_valid", 32'(bus_a.cmp_valid), 0);
        chk("midrst_result", 32'(bus_a.result), 0);
        chk("midrst_N_counter", 32'(bus_a.N_counter), 0);
        repeat (9) step(1'b0, 8, 12, 1'b0, 3);

        // Randomized traffic
        rm = 3;
        rn = 6;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                rm = int'($urandom_range(0, 4));
                rn = 2 * rm + int'($urandom_range(0, 2)) - 1;
                if (rn < 0) rn = 0;
            end
            rev  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 2;
            rsel = ($urandom_range(0, 19) == 0);
            step(($urandom_range(0, 199) == 0), rm, rn, rsel, rev);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
